frame_write_buffer: RTL and testbench

//  Downstream of the display-select/arbiter stage. Buffers its per-pixel output pair
//  (oWr1_data, oWr2_data, oWr_data_valid) in a small FIFO and moves it to the SDRAM

---
 rtl/frame_write_buffer.sv | 226 ++++++++++++++++++++++
 tb/tb_frame_write_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_buffer.sv
// ---------------------------------------------------------------------------
// frame_write_buffer
//
// Buffers pixel pairs from the display-select/arbiter stage in a small FIFO and
// hands them to the SDRAM controller as fixed-length bursts under a
// request/grant handshake. Frames alternate between two SDRAM buffers. The
// display reader is pointed at whichever buffer was finished most recently.
//
// Ports
//   iClk, iRst_n      clock; asynchronous active-low reset
//   iFval             sensor frame valid (rise opens a frame, fall closes it)
//   iWr1_data/iWr2_data/iWr_val
//                     incoming pixel pair and its valid strobe
//   oBurstReq/oBurstLen/iBurstGnt
//                     burst request, its length (1..BURST_LEN), one-cycle grant
//   oSdData/oSdAddr/oSdVal/iSdRdy
//                     word stream to the controller; a word moves on oSdVal&iSdRdy
//   oFrameDone        one-cycle pulse once a frame is completely written
//   oRdBuf            buffer index the display reader may use
//   oOverflow         sticky flag: at least one pair was dropped this frame
//   oDropCnt          dropped pairs this frame, saturating
// ---------------------------------------------------------------------------
module frame_write_buffer #(
   parameter int          DEPTH     = 16,
   parameter int          BURST_LEN = 8,
   parameter logic [22:0] BUF0_BASE = 23'h000000,
   parameter logic [22:0] BUF1_BASE = 23'h100000
) (
   input  logic        iClk,
   input  logic        iRst_n,
   input  logic        iFval,
   input  logic [15:0] iWr1_data,
   input  logic [15:0] iWr2_data,
   input  logic        iWr_val,
   output logic        oBurstReq,
   output logic [3:0]  oBurstLen,
   input  logic        iBurstGnt,
   output logic [31:0] oSdData,
   output logic [22:0] oSdAddr,
   output logic        oSdVal,
   input  logic        iSdRdy,
   output logic        oFrameDone,
   output logic        oRdBuf,
   output logic        oOverflow,
   output logic [15:0] oDropCnt
);

   localparam int              AW         = $clog2(DEPTH);
   localparam int              CW         = AW + 1;
   localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0]   BURST_C    = CW'(BURST_LEN);
   localparam logic [3:0]      BURST_LEN4 = 4'(BURST_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACTIVE,
      S_REQ,
      S_XFER,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t          state_reg;
   logic            fval_reg;
   logic            fell_reg;       // iFval fell while a burst was in flight
   logic            wr_buf_reg;     // buffer currently being written
   logic [19:0]     index_reg;      // word index within the frame
   logic [3:0]      burst_rem_reg;  // words left in the current burst

   logic [31:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;

   logic            fval_rise;
   logic            fval_fall;
   logic            accepting;
   logic            fifo_full;
   logic            push;
   logic            pop;
   logic            drop;
   logic [22:0]     base_addr;
   logic [19:0]     index_next;
   logic [3:0]      flush_len;

   assign fval_rise  = iFval & ~fval_reg;
   assign fval_fall  = ~iFval & fval_reg;

   assign accepting  = (state_reg == S_ACTIVE) || (state_reg == S_REQ) ||
                       (state_reg == S_XFER);
   // Full is judged on the count at cycle start, so a same-cycle pop does not
   // make room for an incoming pair.
   assign fifo_full  = (count_reg == DEPTH_C);
   assign push       = iWr_val & accepting & ~fifo_full;
   assign drop       = iWr_val & ((accepting & fifo_full) ||
                                  (state_reg == S_FLUSH) || (state_reg == S_DONE));

   assign oSdVal     = (state_reg == S_XFER);
   assign pop        = oSdVal & iSdRdy;
   // Head word is presented straight from the array; forced to zero when idle
   // so nothing stale shows up on the bus.
   assign oSdData    = oSdVal ? mem[rd_ptr_reg] : 32'd0;

   assign base_addr  = wr_buf_reg ? BUF1_BASE : BUF0_BASE;
   assign index_next = index_reg + 20'd1;
   assign flush_len  = (count_reg >= BURST_C) ? BURST_LEN4 : 4'(count_reg);

   // FIFO storage: write-only port here, read side is the head index above.
   always_ff @(posedge iClk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {iWr1_data, iWr2_data};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Frame / burst sequencer with registered outputs
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_reg     <= S_IDLE;
         fval_reg      <= 1'b0;
         fell_reg      <= 1'b0;
         wr_buf_reg    <= 1'b0;
         index_reg     <= '0;
         burst_rem_reg <= '0;
         oBurstReq     <= 1'b0;
         oBurstLen     <= '0;
         oSdAddr       <= '0;
         oFrameDone    <= 1'b0;
         oRdBuf        <= 1'b1;
         oOverflow     <= 1'b0;
         oDropCnt      <= '0;
      end else begin
         fval_reg   <= iFval;
         oFrameDone <= 1'b0;

         if (drop) begin
            oOverflow <= 1'b1;
            if (oDropCnt != 16'hFFFF) oDropCnt <= oDropCnt + 16'd1;
         end

         case (state_reg)
            S_IDLE: begin
               if (fval_rise) begin
                  state_reg <= S_ACTIVE;
                  index_reg <= '0;
                  oSdAddr   <= base_addr;
                  oOverflow <= 1'b0;
                  oDropCnt  <= '0;
                  fell_reg  <= 1'b0;
               end
            end

            S_ACTIVE: begin
               // End of frame wins over a pending full burst: FLUSH
               // drains it anyway.
               if (fval_fall) begin
                  state_reg <= S_FLUSH;
               end else if (count_reg >= BURST_C) begin
                  state_reg <= S_REQ;
                  oBurstReq <= 1'b1;
                  oBurstLen <= BURST_LEN4;
               end
            end

            S_REQ: begin
               if (fval_fall) fell_reg <= 1'b1;
               if (iBurstGnt) begin
                  state_reg     <= S_XFER;
                  oBurstReq     <= 1'b0;
                  burst_rem_reg <= oBurstLen;
               end
            end

            S_XFER: begin
               if (fval_fall) fell_reg <= 1'b1;
               if (pop) begin
                  index_reg     <= index_next;
                  oSdAddr       <= base_addr + 23'(index_next);
                  burst_rem_reg <= burst_rem_reg - 4'd1;
                  if (burst_rem_reg == 4'd1) begin
                     state_reg <= (fell_reg | fval_fall) ? S_FLUSH : S_ACTIVE;
                  end
               end
            end

            S_FLUSH: begin
               // Bursts launched from here must come back here.
               fell_reg <= 1'b1;
               if (count_reg == '0) begin
                  state_reg  <= S_DONE;
                  oFrameDone <= 1'b1;
               end else begin
                  state_reg <= S_REQ;
                  oBurstReq <= 1'b1;
                  oBurstLen <= flush_len;
               end
            end

            S_DONE: begin
               oRdBuf     <= wr_buf_reg;
               wr_buf_reg <= ~wr_buf_reg;
               state_reg  <= S_IDLE;
            end

            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_frame_write_buffer
//
// Scoreboard bench: each accepted pixel pair pushes its expected SDRAM word and
// address; the monitor pops and compares whenever a word is handed over.
// Burst lengths seen at grant time are collected and compared per frame.
// ---------------------------------------------------------------------------
module tb_frame_write_buffer;

   logic        iClk = 1'b0;
   logic        iRst_n;
   logic        iFval;
   logic [15:0] iWr1_data;
   logic [15:0] iWr2_data;
   logic        iWr_val;
   logic        oBurstReq;
   logic [3:0]  oBurstLen;
   logic        iBurstGnt;
   logic [31:0] oSdData;
   logic [22:0] oSdAddr;
   logic        oSdVal;
   logic        iSdRdy;
   logic        oFrameDone;
   logic        oRdBuf;
   logic        oOverflow;
   logic [15:0] oDropCnt;

   always #5 iClk = ~iClk;

   frame_write_buffer dut (
      .iClk       (iClk),
      .iRst_n     (iRst_n),
      .iFval      (iFval),
      .iWr1_data  (iWr1_data),
      .iWr2_data  (iWr2_data),
      .iWr_val    (iWr_val),
      .oBurstReq  (oBurstReq),
      .oBurstLen  (oBurstLen),
      .iBurstGnt  (iBurstGnt),
      .oSdData    (oSdData),
      .oSdAddr    (oSdAddr),
      .oSdVal     (oSdVal),
      .iSdRdy     (iSdRdy),
      .oFrameDone (oFrameDone),
      .oRdBuf     (oRdBuf),
      .oOverflow  (oOverflow),
      .oDropCnt   (oDropCnt)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [22:0] addr;
   } exp_t;

   exp_t        sb_q[$];
   logic [3:0]  bl_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_words  = 0;
   int          n_done   = 0;
   bit          gnt_en   = 1'b1;
   int          rdy_mode = 0;      // 0: always ready, 1: toggling, 2: never
   bit          wr_buf_model = 1'b0;
   logic [19:0] idx_model;
   logic [22:0] base_model;
   int          frame_no = 0;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge iClk);
      #1;
   endtask

   // Grant responder: grant arrives two cycles after the request is seen.
   initial begin
      iBurstGnt = 1'b0;
      forever begin
         @(posedge iClk);
         #1;
         if (gnt_en && iRst_n && oBurstReq) begin
            bl_q.push_back(oBurstLen);
            $display("grant: burst len %0d", oBurstLen);
            @(posedge iClk);
            #1;
            iBurstGnt = 1'b1;
            @(posedge iClk);
            #1;
            iBurstGnt = 1'b0;
         end
      end
   end

   // Controller ready pattern
   initial begin
      iSdRdy = 1'b1;
      forever begin
         @(posedge iClk);
         #1;
         case (rdy_mode)
            0:       iSdRdy = 1'b1;
            1:       iSdRdy = ~iSdRdy;
            default: iSdRdy = 1'b0;
         endcase
      end
   end

   // Output monitor, sampled mid-cycle
   always @(negedge iClk) begin
      exp_t e;
      if (iRst_n) begin
         if (oFrameDone) n_done++;
         if (oSdVal && iSdRdy) begin
            n_words++;
            if (sb_q.size() == 0) begin
               check_val("sd_unexpected_word", 32'(oSdVal), 32'd0);
            end else begin
               e = sb_q.pop_front();
               check_val("sd_data", oSdData, e.data);
               check_val("sd_addr", 32'(oSdAddr), 32'(e.addr));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_outputs(input string pfx);
      check_val({pfx, "_burst_req"},  32'(oBurstReq),  32'd0);
      check_val({pfx, "_burst_len"},  32'(oBurstLen),  32'd0);
      check_val({pfx, "_sd_val"},     32'(oSdVal),     32'd0);
      check_val({pfx, "_sd_addr"},    32'(oSdAddr),    32'd0);
      check_val({pfx, "_sd_data"},    oSdData,         32'd0);
      check_val({pfx, "_frame_done"}, 32'(oFrameDone), 32'd0);
      check_val({pfx, "_rd_buf"},     32'(oRdBuf),     32'd1);
      check_val({pfx, "_overflow"},   32'(oOverflow),  32'd0);
      check_val({pfx, "_drop_cnt"},   32'(oDropCnt),   32'd0);
   endtask

   task automatic send_pairs(input int n, input int keep);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         iWr1_data = 16'($urandom);
         iWr2_data = 16'($urandom);
         iWr_val   = 1'b1;
         if (i < keep) begin
            e.data = {iWr1_data, iWr2_data};
            e.addr = base_model + 23'(idx_model);
            sb_q.push_back(e);
            idx_model++;
         end
         tick();
      end
      iWr_val = 1'b0;
   endtask

   task automatic open_frame;
      bl_q.delete();
      n_words    = 0;
      n_done     = 0;
      base_model = wr_buf_model ? 23'h100000 : 23'h000000;
      idx_model  = '0;
      iFval      = 1'b1;
      repeat (3) tick();
   endtask

   task automatic run_frame(input int n, input int keep, input logic [3:0] l0,
                            input logic [3:0] l1, input bit stall);
      bit got_done;
      frame_no++;
      open_frame();
      check_val("ovf_clear_at_start",  32'(oOverflow), 32'd0);
      check_val("drop_clear_at_start", 32'(oDropCnt),  32'd0);
      if (stall) gnt_en = 1'b0;
      send_pairs(n, keep);
      if (stall) begin
         tick();
         check_val("overflow_set",  32'(oOverflow), 32'd1);
         check_val("drop_cnt",      32'(oDropCnt),  32'(n - keep));
         check_val("req_while_stalled", 32'(oBurstReq), 32'd1);
         gnt_en = 1'b1;
      end
      repeat (30) tick();
      iFval = 1'b0;
      got_done = 1'b0;
      for (int i = 0; i < 300 && !got_done; i++) begin
         tick();
         if (oFrameDone) got_done = 1'b1;
      end
      check_val("frame_done_seen", 32'(got_done), 32'd1);
      tick();
      check_val("rd_buf_after_frame", 32'(oRdBuf), 32'(wr_buf_model));
      check_val("frame_done_pulses",  32'(n_done), 32'd1);
      check_val("words_written",      32'(n_words), 32'(keep));
      check_val("scoreboard_empty",   32'(sb_q.size()), 32'd0);
      check_val("burst_count",        32'(bl_q.size()), 32'd2);
      if (bl_q.size() >= 2) begin
         check_val("burst0_len", 32'(bl_q[0]), 32'(l0));
         check_val("burst1_len", 32'(bl_q[1]), 32'(l1));
      end
      $display("frame %0d: base %h pairs %0d words %0d rd_buf %0d",
               frame_no, base_model, n, n_words, oRdBuf);
      wr_buf_model = ~wr_buf_model;
   endtask

   initial begin
      bit got_val;
      iRst_n    = 1'b0;
      iFval     = 1'b0;
      iWr_val   = 1'b0;
      iWr1_data = '0;
      iWr2_data = '0;
      repeat (3) tick();
      check_reset_outputs("reset");
      iRst_n = 1'b1;
      tick();

      // Full bursts, buffer 0, addresses 0..15
      run_frame(16, 16, 4'd8, 4'd8, 1'b0);
      // Second frame goes to buffer 1
      run_frame(13, 13, 4'd8, 4'd5, 1'b0);
      // Third frame back at buffer 0; flush burst of 5 at addresses 8..12
      run_frame(13, 13, 4'd8, 4'd5, 1'b0);
      // No grant while 20 pairs arrive: 16 kept, 4 dropped
      run_frame(20, 16, 4'd8, 4'd8, 1'b1);
      // Controller ready toggling during transfers
      rdy_mode = 1;
      run_frame(10, 10, 4'd8, 4'd2, 1'b0);

      // Reset in the middle of a transfer
      frame_no++;
      open_frame();
      send_pairs(12, 12);
      got_val = 1'b0;
      for (int i = 0; i < 50 && !got_val; i++) begin
         if (oSdVal) got_val = 1'b1;
         else tick();
      end
      check_val("xfer_reached", 32'(got_val), 32'd1);
      tick();
      iRst_n = 1'b0;
      iFval  = 1'b0;
      #2;
      check_reset_outputs("midxfer_reset");
      $display("frame %0d: reset during transfer after %0d words", frame_no, n_words);
      sb_q.delete();
      wr_buf_model = 1'b0;
      rdy_mode = 0;
      repeat (2) tick();
      iRst_n = 1'b1;
      tick();

      // After reset the next frame starts again at buffer 0, address 0
      run_frame(9, 9, 4'd8, 4'd1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
